// File: rtl/huffman_encoder_if.sv
// Stream interface for the fixed-codebook Huffman encoder: symbol input side
// and packed-word output side.
interface huffman_encoder_if #(
    parameter int unsigned OUT_W = 16
);
    localparam int unsigned NB = $clog2(OUT_W + 1);

    logic [3:0]       in_symbol;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_last;
    logic [NB-1:0]    out_nbits;
    logic             out_ready;

    // Symbol source / word sink side
    modport master (
        output in_symbol, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_nbits
    );

    // Encoder side
    modport slave (
        input  in_symbol, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_nbits
    );
endinterface

// File: rtl/huffman_encoder.sv
// Fixed-codebook Huffman encoder. Codes are appended MSB-first into a
// left-justified accumulator and drained in OUT_W-bit words; the final word of
// a stream is zero-padded and tagged with out_last.
module huffman_encoder #(
    parameter int unsigned OUT_W = 16
) (
    input logic               clk,
    input logic               rst,
    huffman_encoder_if.slave  bus
);
    localparam int unsigned NB = $clog2(OUT_W + 1);
    localparam int unsigned AW = OUT_W + 10;
    localparam int unsigned CW = $clog2(OUT_W + 10);
    localparam logic [CW-1:0] OutWC = CW'(OUT_W);

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [NB-1:0]    out_nbits_q, out_nbits_d;

    logic [9:0]       code_val;
    logic [3:0]       code_len;
    logic [9:0]       code_lj;
    logic [AW-1:0]    code_app;
    logic             in_ready;
    logic             accept;
    logic             slot_free;

    // Codebook lookup: right-justified code value and its length
    always_comb begin
        code_val = 10'd0;
        code_len = 4'd0;
        if (bus.in_symbol == 4'd0) begin
            code_val = 10'd1;
            code_len = 4'd1;
        end else if (bus.in_symbol <= 4'd6) begin
            code_val = 10'(bus.in_symbol - 4'd1);
            code_len = 4'd4;
        end else if (bus.in_symbol <= 4'd8) begin
            code_val = 10'd12 + 10'(bus.in_symbol - 4'd7);
            code_len = 4'd5;
        end else if (bus.in_symbol <= 4'd11) begin
            code_val = 10'd28 + 10'(bus.in_symbol - 4'd9);
            code_len = 4'd6;
        end else begin
            code_val = 10'd496 + 10'(bus.in_symbol - 4'd12);
            code_len = 4'd10;
        end
    end

    // Place the code just below the bits already held in the accumulator
    assign code_lj  = code_val << (4'd10 - code_len);
    assign code_app = {code_lj, {OUT_W{1'b0}}} >> cnt_q;

    assign in_ready  = (state_q == StRun) && (cnt_q < OutWC);
    assign accept    = bus.in_valid && in_ready;
    assign slot_free = !out_valid_q || bus.out_ready;

    // Next-state: append on accept, otherwise emit a word when the slot frees up.
    // Bits below cnt are always zero, so flush words come out zero-padded.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_nbits_d = out_nbits_q;
        out_valid_d = out_valid_q && !bus.out_ready;

        if (accept) begin
            acc_d = acc_q | code_app;
            cnt_d = cnt_q + CW'(code_len);
            if (bus.in_last) begin
                state_d = StFlush;
            end
        end else if (slot_free) begin
            unique case (state_q)
                StRun: begin
                    if (cnt_q >= OutWC) begin
                        out_data_d  = acc_q[AW-1:10];
                        acc_d       = acc_q << OUT_W;
                        cnt_d       = cnt_q - OutWC;
                        out_last_d  = 1'b0;
                        out_nbits_d = NB'(OUT_W);
                        out_valid_d = 1'b1;
                    end
                end
                StFlush: begin
                    if (cnt_q == '0) begin
                        state_d = StRun;
                    end else begin
                        out_data_d  = acc_q[AW-1:10];
                        acc_d       = acc_q << OUT_W;
                        out_valid_d = 1'b1;
                        if (cnt_q <= OutWC) begin
                            cnt_d       = '0;
                            out_last_d  = 1'b1;
                            out_nbits_d = NB'(cnt_q);
                            state_d     = StRun;
                        end else begin
                            cnt_d       = cnt_q - OutWC;
                            out_last_d  = 1'b0;
                            out_nbits_d = NB'(OUT_W);
                        end
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_nbits_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_nbits_q <= out_nbits_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_nbits = out_nbits_q;
endmodule

// File: tb/tb_huffman_encoder.sv
// Directed bench for huffman_encoder (OUT_W = 16): codebook table plus
// hand-written stream, backpressure and reset sequences.
module tb_huffman_encoder;
    localparam int unsigned OUT_W = 16;

    typedef struct packed {
        logic [15:0] data;
        logic [4:0]  nbits;
        logic        last;
    } word_t;

    typedef struct {
        logic [3:0]  sym;
        logic [15:0] word;
        logic [4:0]  nbits;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    word_t got_q[$];
    vec_t  tbl[16];

    always #5 clk = ~clk;

    huffman_encoder_if #(.OUT_W(OUT_W)) bus ();

    huffman_encoder #(.OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Record each word at the negedge before the edge that consumes it
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            got_q.push_back({bus.out_data, bus.out_nbits, bus.out_last});
        end
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [3:0] sym, logic last);
        int n = 0;
        bus.in_symbol = sym;
        bus.in_last   = last;
        bus.in_valid  = 1'b1;
        while (!bus.in_ready && n < 300) begin
            cyc();
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end
        cyc();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic get_word(output word_t w);
        int n = 0;
        while (got_q.size() == 0 && n < 100) begin
            cyc();
            n++;
        end
        if (got_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL word_timeout actual=none required=word");
            w = '0;
        end else begin
            w = got_q.pop_front();
        end
    endtask

    initial begin
        word_t w;
        logic  exp_bits[$];
        logic [15:0] exp_first;
        logic [15:0] e;
        int nb;
        int k;

        tbl[0]  = '{4'd0,  16'h8000, 5'd1};
        tbl[1]  = '{4'd1,  16'h0000, 5'd4};
        tbl[2]  = '{4'd2,  16'h1000, 5'd4};
        tbl[3]  = '{4'd3,  16'h2000, 5'd4};
        tbl[4]  = '{4'd4,  16'h3000, 5'd4};
        tbl[5]  = '{4'd5,  16'h4000, 5'd4};
        tbl[6]  = '{4'd6,  16'h5000, 5'd4};
        tbl[7]  = '{4'd7,  16'h6000, 5'd5};
        tbl[8]  = '{4'd8,  16'h6800, 5'd5};
        tbl[9]  = '{4'd9,  16'h7000, 5'd6};
        tbl[10] = '{4'd10, 16'h7400, 5'd6};
        tbl[11] = '{4'd11, 16'h7800, 5'd6};
        tbl[12] = '{4'd12, 16'h7C00, 5'd10};
        tbl[13] = '{4'd13, 16'h7C40, 5'd10};
        tbl[14] = '{4'd14, 16'h7C80, 5'd10};
        tbl[15] = '{4'd15, 16'h7CC0, 5'd10};

        // Reset and idle
        bus.in_symbol = 4'd0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_nbits", 64'(bus.out_nbits), 64'd0);
        repeat (5) cyc();
        check("idle_no_word", 64'(got_q.size()), 64'd0);
        check("idle_out_valid", 64'(bus.out_valid), 64'd0);

        // 16 x sym0 without last: one full word, in_ready low only for the emit cycle
        for (int i = 0; i < 16; i++) send(4'd0, 1'b0);
        check("full_in_ready_low", 64'(bus.in_ready), 64'd0);
        check("full_latency_valid", 64'(bus.out_valid), 64'd0);
        cyc();
        check("full_in_ready_back", 64'(bus.in_ready), 64'd1);
        check("full_out_valid", 64'(bus.out_valid), 64'd1);
        get_word(w);
        check("full_data", 64'(w.data), 64'hFFFF);
        check("full_nbits", 64'(w.nbits), 64'd16);
        check("full_last", 64'(w.last), 64'd0);
        repeat (4) cyc();
        check("full_no_extra", 64'(got_q.size()), 64'd0);

        // sym12, sym1, sym7(last): 19 bits over two words
        send(4'd12, 1'b0);
        send(4'd1, 1'b0);
        send(4'd7, 1'b1);
        get_word(w);
        check("mix_w0_data", 64'(w.data), 64'h7C01);
        check("mix_w0_nbits", 64'(w.nbits), 64'd16);
        check("mix_w0_last", 64'(w.last), 64'd0);
        get_word(w);
        check("mix_w1_data", 64'(w.data), 64'h8000);
        check("mix_w1_nbits", 64'(w.nbits), 64'd3);
        check("mix_w1_last", 64'(w.last), 64'd1);
        repeat (3) cyc();
        check("mix_in_ready", 64'(bus.in_ready), 64'd1);
        check("mix_no_extra", 64'(got_q.size()), 64'd0);

        // Exactly one full word ending the stream: no empty trailing word
        for (int i = 0; i < 16; i++) send(4'd0, i == 15);
        get_word(w);
        check("exact_data", 64'(w.data), 64'hFFFF);
        check("exact_nbits", 64'(w.nbits), 64'd16);
        check("exact_last", 64'(w.last), 64'd1);
        repeat (5) cyc();
        check("exact_no_extra", 64'(got_q.size()), 64'd0);

        // Codebook table: each symbol as its own one-symbol stream
        for (int i = 0; i < 16; i++) begin
            send(tbl[i].sym, 1'b1);
            get_word(w);
            check($sformatf("tbl%0d_data", i), 64'(w.data), 64'(tbl[i].word));
            check($sformatf("tbl%0d_nbits", i), 64'(w.nbits), 64'(tbl[i].nbits));
            check($sformatf("tbl%0d_last", i), 64'(w.last), 64'd1);
        end
        repeat (3) cyc();
        check("tbl_no_extra", 64'(got_q.size()), 64'd0);

        // Backpressure: 6 x sym15 with out_ready low, then release
        for (int s = 0; s < 6; s++) begin
            for (int b = 0; b < int'(tbl[15].nbits); b++) begin
                exp_bits.push_back(tbl[15].word[15-b]);
            end
        end
        for (int i = 0; i < 16; i++) exp_first[15-i] = exp_bits[i];
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(4'd15, i == 5);
            end
            begin
                repeat (10) cyc();
                check("bp_out_valid", 64'(bus.out_valid), 64'd1);
                check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
                check("bp_first_data", 64'(bus.out_data), 64'(exp_first));
                repeat (4) cyc();
                check("bp_hold_data", 64'(bus.out_data), 64'(exp_first));
                check("bp_hold_nbits", 64'(bus.out_nbits), 64'd16);
                check("bp_hold_last", 64'(bus.out_last), 64'd0);
                bus.out_ready = 1'b1;
            end
        join
        k = 0;
        while (exp_bits.size() > 0 && k < 8) begin
            nb = (exp_bits.size() > 16) ? 16 : exp_bits.size();
            e = '0;
            for (int i = 0; i < nb; i++) e[15-i] = exp_bits.pop_front();
            get_word(w);
            check($sformatf("bp_w%0d_data", k), 64'(w.data), 64'(e));
            check($sformatf("bp_w%0d_nbits", k), 64'(w.nbits), 64'(nb));
            check($sformatf("bp_w%0d_last", k), 64'(w.last), 64'(exp_bits.size() == 0));
            k++;
        end
        repeat (4) cyc();
        check("bp_no_extra", 64'(got_q.size()), 64'd0);

        // Reset during FLUSH with bits pending, then a clean stream
        bus.out_ready = 1'b0;
        send(4'd15, 1'b0);
        send(4'd15, 1'b1);
        cyc();
        cyc();
        check("rf_pending_valid", 64'(bus.out_valid), 64'd1);
        check("rf_in_ready_low", 64'(bus.in_ready), 64'd0);
        rst = 1'b1;
        cyc();
        check("rf_out_valid", 64'(bus.out_valid), 64'd0);
        check("rf_in_ready", 64'(bus.in_ready), 64'd1);
        rst = 1'b0;
        got_q.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(4'd0, i == 15);
        get_word(w);
        check("rf_new_data", 64'(w.data), 64'hFFFF);
        check("rf_new_nbits", 64'(w.nbits), 64'd16);
        check("rf_new_last", 64'(w.last), 64'd1);
        repeat (5) cyc();
        check("rf_no_extra", 64'(got_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/huffman_encoder.md
Name: huffman_encoder

Overview:
Fixed-codebook Huffman encoder. It accepts 4-bit weight symbols and emits the prefix-code bitstream that huffman_decoder consumes, packed MSB-first into OUT_W-bit words. The first code bit of the stream lands in out_data[OUT_W-1]. It sits upstream of the decoder: on the compression/writer side of the weight path, or as the golden stream source in decoder benches.

Parameters:
OUT_W, 16, output word width in bits; legal range 10..64.
NB, $clog2(OUT_W+1), width of out_nbits (localparam).

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_symbol  input  4  symbol to encode
in_valid  input  1  in_symbol valid
in_last  input  1  qualifies in_symbol as the final symbol of a stream
in_ready  output  1  encoder can accept a symbol this cycle
out_data  output  OUT_W  packed code word, MSB = earliest bit
out_valid  output  1  out_data valid
out_last  output  1  final word of the stream (with out_valid)
out_nbits  output  NB  number of meaningful bits in out_data, counted from the MSB
out_ready  input  1  downstream accepts out_data

Behaviour:
- Codebook, fixed, lengths {1,4,5,6,10}:
  - sym0 = 1
  - sym1..6 = 0000, 0001, 0010, 0011, 0100, 0101
  - sym7 = 01100, sym8 = 01101
  - sym9 = 011100, sym10 = 011101, sym11 = 011110
  - sym12..15 = 0111110000, 0111110001, 0111110010, 0111110011
- Storage: bit accumulator acc[OUT_W+9:0], left-justified, plus fill count cnt (0..OUT_W+9). Output register holds out_data/out_last/out_nbits.
- States: RUN, FLUSH.
- in_ready = (state==RUN) && (cnt < OUT_W). It is a function of registered state only.
- Input handshake: in_valid && in_ready at an edge appends the code at acc[OUT_W+9-cnt] downward, and cnt += len. If in_last was set, next state is FLUSH.
- Emit condition: out slot free, i.e. !out_valid || out_ready.
  - RUN: emit when cnt >= OUT_W. out_data = acc[OUT_W+9:10]; acc <<= OUT_W; cnt -= OUT_W; out_last = 0; out_nbits = OUT_W.
  - FLUSH: emit when cnt > 0. Same, but bits beyond cnt are zero-padded. out_nbits = min(cnt, OUT_W). out_last = 1 iff cnt <= OUT_W. Return to RUN once cnt reaches 0.
- Append and emit never occur in the same cycle in RUN, because in_ready requires cnt < OUT_W.
- Latency: the symbol accepted at edge k that makes cnt >= OUT_W gives out_valid high after edge k+1, if the slot is free.
- Output stability: out_data, out_last and out_nbits stay stable while out_valid && !out_ready. out_valid clears at an out_ready edge unless a new word loads on that same edge.
- No bits are ever dropped. in_valid while in_ready is low is ignored, and the source must hold.
- Reset values: out_valid = 0, out_last = 0, out_data = 0, out_nbits = 0, in_ready = 1 (cnt = 0, state = RUN).
- rst asserted mid-stream or mid-flush discards acc and the pending word at the next edge.
- If cnt hits exactly 0 in FLUSH after a full word, that word carries out_last = 1 and out_nbits = OUT_W. No empty word is ever emitted.

Test Plan:
1. Reset: rst high for 2 cycles, then low -> out_valid = 0, out_last = 0, in_ready = 1. No output while in_valid = 0.
2. 16 x sym0, no in_last, out_ready = 1 -> one word 0xFFFF, out_nbits = 16, out_last = 0. in_ready drops for exactly the emit cycle.
3. sym12, sym1, sym7 (in_last on sym7) -> word 0x7C01 (nbits 16, last 0), then 0x8000 (nbits 3, last 1). in_ready returns to 1 after the final word.
4. 16 x sym0 with in_last on the 16th -> single word 0xFFFF with out_last = 1, out_nbits = 16, and no extra word.
5. Backpressure: out_ready = 0, stream sym15 repeatedly -> first word is held stable, in_ready falls once cnt >= 16. Releasing out_ready produces words with no bit loss; the concatenated stream equals the codes in order.
6. rst pulsed during FLUSH with bits pending -> out_valid = 0 next cycle, in_ready = 1. A new stream of sym0 x 16 yields 0xFFFF with no stale bits.
